// File: rtl/bc_game_controller.sv
// Bulls & Cows game sequencer: secret entry, alternating guess turns, serial
// digit-by-digit scoring, match points and winner tracking.
module bc_game_controller #(
    parameter int unsigned POINT_W = 4,
    parameter int unsigned GUESS_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        code,
    input  logic               enter_button,
    output logic [2:0]         phase,
    output logic               turn,
    output logic [2:0]         bulls,
    output logic [2:0]         cows,
    output logic               result_valid,
    output logic               error,
    output logic               winner,
    output logic [POINT_W-1:0] p1_points,
    output logic [POINT_W-1:0] p2_points,
    output logic [GUESS_W-1:0] guess_count
);
    typedef enum logic [2:0] {
        StSetP1  = 3'd0,
        StSetP2  = 3'd1,
        StGuess  = 3'd2,
        StScore  = 3'd3,
        StResult = 3'd4,
        StWin    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        secret1_q, secret1_d, secret2_q, secret2_d, guess_q, guess_d;
    logic               turn_q, turn_d, winner_q, winner_d;
    logic [1:0]         idx_q, idx_d;
    logic [2:0]         bull_acc_q, bull_acc_d, cow_acc_q, cow_acc_d;
    logic [2:0]         bulls_q, bulls_d, cows_q, cows_d;
    logic [POINT_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [GUESS_W-1:0] gcnt_q, gcnt_d;
    logic               err_q, err_d, rv_q, rv_d, enter_q;
    logic               press, code_valid, g_bull, g_cow;
    logic [15:0]        target;
    logic [3:0]         g_dig;

    assign press  = enter_button & ~enter_q;
    assign target = turn_q ? secret1_q : secret2_q;
    assign g_dig  = guess_q[{idx_q, 2'b00} +: 4];

    // Four BCD digits, all pairwise distinct.
    always_comb begin
        code_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (code[i*4 +: 4] > 4'd9) code_valid = 1'b0;
            for (int j = i + 1; j < 4; j++) begin
                if (code[i*4 +: 4] == code[j*4 +: 4]) code_valid = 1'b0;
            end
        end
    end

    always_comb begin
        g_bull = (g_dig == target[{idx_q, 2'b00} +: 4]);
        g_cow  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (g_dig == target[i*4 +: 4]) g_cow = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        secret1_d  = secret1_q;
        secret2_d  = secret2_q;
        guess_d    = guess_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        idx_d      = idx_q;
        bull_acc_d = bull_acc_q;
        cow_acc_d  = cow_acc_q;
        bulls_d    = bulls_q;
        cows_d     = cows_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        gcnt_d     = gcnt_q;
        err_d      = 1'b0;
        rv_d       = 1'b0;
        unique case (state_q)
            StSetP1: begin
                if (press) begin
                    if (code_valid) begin
                        secret1_d = code;
                        state_d   = StSetP2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSetP2: begin
                if (press) begin
                    if (code_valid) begin
                        secret2_d = code;
                        turn_d    = 1'b0;
                        state_d   = StGuess;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGuess: begin
                if (press) begin
                    if (code_valid) begin
                        guess_d    = code;
                        bull_acc_d = 3'd0;
                        cow_acc_d  = 3'd0;
                        idx_d      = 2'd0;
                        gcnt_d     = (&gcnt_q) ? gcnt_q : gcnt_q + 1'b1;
                        state_d    = StScore;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StScore: begin
                if (g_bull) begin
                    bull_acc_d = bull_acc_q + 3'd1;
                end else if (g_cow) begin
                    cow_acc_d = cow_acc_q + 3'd1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = StResult;
            end
            StResult: begin
                bulls_d = bull_acc_q;
                cows_d  = cow_acc_q;
                rv_d    = 1'b1;
                if (bull_acc_q == 3'd4) begin
                    winner_d = turn_q;
                    if (turn_q) p2_d = (&p2_q) ? p2_q : p2_q + 1'b1;
                    else        p1_d = (&p1_q) ? p1_q : p1_q + 1'b1;
                    state_d = StWin;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = StGuess;
                end
            end
            StWin: begin
                // Any press starts a new game; the code word is not looked at.
                if (press) begin
                    secret1_d = 16'h0;
                    secret2_d = 16'h0;
                    gcnt_d    = '0;
                    turn_d    = 1'b0;
                    state_d   = StSetP1;
                end
            end
            default: state_d = StSetP1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StSetP1;
            secret1_q  <= 16'h0;
            secret2_q  <= 16'h0;
            guess_q    <= 16'h0;
            turn_q     <= 1'b0;
            winner_q   <= 1'b0;
            idx_q      <= 2'd0;
            bull_acc_q <= 3'd0;
            cow_acc_q  <= 3'd0;
            bulls_q    <= 3'd0;
            cows_q     <= 3'd0;
            p1_q       <= '0;
            p2_q       <= '0;
            gcnt_q     <= '0;
            err_q      <= 1'b0;
            rv_q       <= 1'b0;
            enter_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            secret1_q  <= secret1_d;
            secret2_q  <= secret2_d;
            guess_q    <= guess_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            idx_q      <= idx_d;
            bull_acc_q <= bull_acc_d;
            cow_acc_q  <= cow_acc_d;
            bulls_q    <= bulls_d;
            cows_q     <= cows_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            gcnt_q     <= gcnt_d;
            err_q      <= err_d;
            rv_q       <= rv_d;
            enter_q    <= enter_button;
        end
    end

    assign phase        = state_q;
    assign turn         = turn_q;
    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign result_valid = rv_q;
    assign error        = err_q;
    assign winner       = winner_q;
    assign p1_points    = p1_q;
    assign p2_points    = p2_q;
    assign guess_count  = gcnt_q;

endmodule

// File: tb/tb_bc_game_controller.sv
// Directed bench for bc_game_controller: a vector table walking two full games,
// then hand-written sequences for held buttons, dropped presses, async reset, saturation.
module tb_bc_game_controller;
    localparam int unsigned POINT_W = 2;
    localparam int unsigned GUESS_W = 8;

    logic               clock, reset, enter_button;
    logic [15:0]        code;
    logic [2:0]         phase, bulls, cows;
    logic               turn, result_valid, error, winner;
    logic [POINT_W-1:0] p1_points, p2_points;
    logic [GUESS_W-1:0] guess_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] code;
        logic        err;
        logic [2:0]  ph;
        logic        sc;
        logic [2:0]  b;
        logic [2:0]  c;
        logic [2:0]  fph;
        logic        t;
        logic [7:0]  gc;
        logic [1:0]  p1;
        logic [1:0]  p2;
        logic        w;
    } vec_t;

    vec_t vecs[19];

    bc_game_controller #(
        .POINT_W(POINT_W),
        .GUESS_W(GUESS_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .code        (code),
        .enter_button(enter_button),
        .phase       (phase),
        .turn        (turn),
        .bulls       (bulls),
        .cows        (cows),
        .result_valid(result_valid),
        .error       (error),
        .winner      (winner),
        .p1_points   (p1_points),
        .p2_points   (p2_points),
        .guess_count (guess_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Guarantees one low edge first so the rising level is seen as a press.
    task automatic press(input logic [15:0] c);
        enter_button = 1'b0;
        tick();
        code = c;
        enter_button = 1'b1;
        tick();
        enter_button = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'd0);
        chk({tag, ".turn"}, 32'(turn), 32'd0);
        chk({tag, ".bulls"}, 32'(bulls), 32'd0);
        chk({tag, ".cows"}, 32'(cows), 32'd0);
        chk({tag, ".rv"}, 32'(result_valid), 32'd0);
        chk({tag, ".err"}, 32'(error), 32'd0);
        chk({tag, ".winner"}, 32'(winner), 32'd0);
        chk({tag, ".p1"}, 32'(p1_points), 32'd0);
        chk({tag, ".p2"}, 32'(p2_points), 32'd0);
        chk({tag, ".gc"}, 32'(guess_count), 32'd0);
    endtask

    initial begin
        // code, err, ph, sc, bulls, cows, final phase, turn, gc, p1, p2, winner
        vecs[0]  = '{16'h1123, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{16'h12A4, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[2]  = '{16'h5678, 1'b0, 3'd1, 1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[3]  = '{16'h1A23, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[4]  = '{16'h1234, 1'b0, 3'd2, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[5]  = '{16'h4431, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0, 3'd2, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0};
        vecs[6]  = '{16'h4321, 1'b0, 3'd3, 1'b1, 3'd0, 3'd4, 3'd2, 1'b1, 8'd1, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{16'h5687, 1'b0, 3'd3, 1'b1, 3'd2, 3'd2, 3'd2, 1'b0, 8'd2, 2'd0, 2'd0, 1'b0};
        vecs[8]  = '{16'h1243, 1'b0, 3'd3, 1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 8'd3, 2'd0, 2'd0, 1'b0};
        vecs[9]  = '{16'h9012, 1'b0, 3'd3, 1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 8'd4, 2'd0, 2'd0, 1'b0};
        vecs[10] = '{16'h5234, 1'b0, 3'd3, 1'b1, 3'd3, 3'd0, 3'd2, 1'b1, 8'd5, 2'd0, 2'd0, 1'b0};
        vecs[11] = '{16'h8765, 1'b0, 3'd3, 1'b1, 3'd0, 3'd4, 3'd2, 1'b0, 8'd6, 2'd0, 2'd0, 1'b0};
        vecs[12] = '{16'h1234, 1'b0, 3'd3, 1'b1, 3'd4, 3'd0, 3'd5, 1'b0, 8'd7, 2'd1, 2'd0, 1'b0};
        vecs[13] = '{16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 8'd0, 2'd1, 2'd0, 1'b0};
        vecs[14] = '{16'h0123, 1'b0, 3'd1, 1'b0, 3'd4, 3'd0, 3'd1, 1'b0, 8'd0, 2'd1, 2'd0, 1'b0};
        vecs[15] = '{16'h4567, 1'b0, 3'd2, 1'b0, 3'd4, 3'd0, 3'd2, 1'b0, 8'd0, 2'd1, 2'd0, 1'b0};
        vecs[16] = '{16'h0123, 1'b0, 3'd3, 1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 8'd1, 2'd1, 2'd0, 1'b0};
        vecs[17] = '{16'h0123, 1'b0, 3'd3, 1'b1, 3'd4, 3'd0, 3'd5, 1'b1, 8'd2, 2'd1, 2'd1, 1'b1};
        vecs[18] = '{16'h1111, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 8'd0, 2'd1, 2'd1, 1'b1};

        reset = 1'b1;
        code = 16'h0;
        enter_button = 1'b0;
        #1 reset = 1'b0;
        #1 chk_zero("reset_async");
        tick();
        tick();
        chk_zero("reset_held");
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            string r;
            r = $sformatf("v%0d", i);
            press(vecs[i].code);
            chk({r, ".err"}, 32'(error), 32'(vecs[i].err));
            chk({r, ".ph"}, 32'(phase), 32'(vecs[i].ph));
            if (vecs[i].sc) begin
                for (int k = 1; k <= 3; k++) begin
                    tick();
                    chk($sformatf("%s.score%0d_ph", r, k), 32'(phase), 32'd3);
                    chk($sformatf("%s.score%0d_rv", r, k), 32'(result_valid), 32'd0);
                end
                tick();
                chk({r, ".result_ph"}, 32'(phase), 32'd4);
                chk({r, ".result_rv"}, 32'(result_valid), 32'd0);
                tick();
                chk({r, ".rv"}, 32'(result_valid), 32'd1);
                chk({r, ".rv_err"}, 32'(error), 32'd0);
                chk({r, ".rv_ph"}, 32'(phase), 32'(vecs[i].fph));
                chk({r, ".rv_bulls"}, 32'(bulls), 32'(vecs[i].b));
                chk({r, ".rv_cows"}, 32'(cows), 32'(vecs[i].c));
            end
            tick();
            chk({r, ".err_end"}, 32'(error), 32'd0);
            chk({r, ".rv_end"}, 32'(result_valid), 32'd0);
            chk({r, ".fph"}, 32'(phase), 32'(vecs[i].fph));
            chk({r, ".turn"}, 32'(turn), 32'(vecs[i].t));
            chk({r, ".gc"}, 32'(guess_count), 32'(vecs[i].gc));
            chk({r, ".p1"}, 32'(p1_points), 32'(vecs[i].p1));
            chk({r, ".p2"}, 32'(p2_points), 32'(vecs[i].p2));
            chk({r, ".winner"}, 32'(winner), 32'(vecs[i].w));
            chk({r, ".bulls"}, 32'(bulls), 32'(vecs[i].b));
            chk({r, ".cows"}, 32'(cows), 32'(vecs[i].c));
        end

        // Held button: one press only.
        code = 16'h1234;
        enter_button = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hold%0d.ph", k), 32'(phase), 32'd1);
            chk($sformatf("hold%0d.err", k), 32'(error), 32'd0);
        end
        enter_button = 1'b0;
        tick();
        chk("hold.after_ph", 32'(phase), 32'd1);

        // Presses landing in SCORE and RESULT are dropped.
        press(16'h5678);
        chk("drop.set2_ph", 32'(phase), 32'd2);
        chk("drop.set2_turn", 32'(turn), 32'd0);
        press(16'h8765);
        chk("drop.k0_ph", 32'(phase), 32'd3);
        code = 16'h5678;
        tick();
        chk("drop.k1_ph", 32'(phase), 32'd3);
        enter_button = 1'b1;
        tick();
        chk("drop.k2_ph", 32'(phase), 32'd3);
        enter_button = 1'b0;
        tick();
        chk("drop.k3_ph", 32'(phase), 32'd3);
        tick();
        chk("drop.k4_ph", 32'(phase), 32'd4);
        enter_button = 1'b1;
        tick();
        chk("drop.k5_ph", 32'(phase), 32'd2);
        chk("drop.k5_rv", 32'(result_valid), 32'd1);
        chk("drop.k5_bulls", 32'(bulls), 32'd0);
        chk("drop.k5_cows", 32'(cows), 32'd4);
        chk("drop.k5_turn", 32'(turn), 32'd1);
        enter_button = 1'b0;
        tick();
        chk("drop.k6_ph", 32'(phase), 32'd2);
        chk("drop.k6_rv", 32'(result_valid), 32'd0);
        chk("drop.k6_gc", 32'(guess_count), 32'd1);
        tick();
        chk("drop.k7_ph", 32'(phase), 32'd2);

        // Async reset in the middle of scoring (idx=2).
        press(16'h1234);
        chk("rst.k0_ph", 32'(phase), 32'd3);
        tick();
        tick();
        #2 reset = 1'b0;
        #1 chk_zero("rst_mid_score");
        #2 reset = 1'b1;
        tick();
        chk_zero("rst_after");
        press(16'h2345);
        chk("rst.resume_ph", 32'(phase), 32'd1);
        chk("rst.resume_err", 32'(error), 32'd0);

        // Point counter saturation over five P1 wins.
        for (int g = 0; g < 5; g++) begin
            string r;
            r = $sformatf("sat%0d", g);
            if (g > 0) begin
                press(16'h2345);
                chk({r, ".set1_ph"}, 32'(phase), 32'd1);
            end
            press(16'h6789);
            chk({r, ".set2_ph"}, 32'(phase), 32'd2);
            chk({r, ".turn"}, 32'(turn), 32'd0);
            chk({r, ".gc0"}, 32'(guess_count), 32'd0);
            press(16'h6789);
            chk({r, ".score_ph"}, 32'(phase), 32'd3);
            repeat (5) tick();
            chk({r, ".rv"}, 32'(result_valid), 32'd1);
            chk({r, ".win_ph"}, 32'(phase), 32'd5);
            chk({r, ".bulls"}, 32'(bulls), 32'd4);
            chk({r, ".winner"}, 32'(winner), 32'd0);
            chk({r, ".p1"}, 32'(p1_points), (g < 3) ? 32'(g + 1) : 32'd3);
            chk({r, ".p2"}, 32'(p2_points), 32'd0);
            chk({r, ".gc1"}, 32'(guess_count), 32'd1);
            press(16'hABCD);
            chk({r, ".new_ph"}, 32'(phase), 32'd0);
            chk({r, ".new_turn"}, 32'(turn), 32'd0);
            chk({r, ".new_gc"}, 32'(guess_count), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bc_game_controller.md
Name: bc_game_controller

Overview:
- Sequencing controller for the two-player Bulls & Cows game datapath.
- Validates and captures both secret codes, then alternates guess turns between players.
- Scores each guess serially, one digit per cycle, against the opponent's secret.
- Tracks match points and declares the winner. Sits between the debounced keypad/switch front-end and the display/score logic.

Parameters:
POINT_W, 4, width of each player's saturating point counter
GUESS_W, 8, width of the saturating per-game guess counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
code  input  16  four BCD digits; digit3=[15:12] .. digit0=[3:0]
enter_button  input  1  debounced level from push button; edge-detected internally
phase  output  3  0=SET_P1 1=SET_P2 2=GUESS 3=SCORE 4=RESULT 5=WIN
turn  output  1  player currently guessing (0=P1 guesses secret2, 1=P2 guesses secret1)
bulls  output  3  bulls of last scored guess (0..4)
cows  output  3  cows of last scored guess (0..4)
result_valid  output  1  one-cycle pulse when bulls/cows update
error  output  1  one-cycle pulse on a rejected (invalid) entry
winner  output  1  valid in WIN: player who guessed correctly
p1_points  output  POINT_W  P1 games won, saturating
p2_points  output  POINT_W  P2 games won, saturating
guess_count  output  GUESS_W  guesses made in current game, saturating

Behaviour:
- Reset (reset=0, async): state SET_P1; secrets, guess, turn, bulls, cows, winner, points, guess_count, digit index and the enter history register all 0; result_valid=0, error=0. Reset asserted mid-operation, including during SCORE, aborts immediately; points are lost.
- press = enter_button & ~enter_q, where enter_q is enter_button registered. A level held over many cycles yields exactly one press.
- Entry is valid iff all four digits are <=9 and pairwise distinct. Validity is combinational on code at the press cycle.
- SET_P1:
  - valid press: secret1<=code, go SET_P2.
  - invalid press: error=1 for the next cycle, stay.
- SET_P2: same rules; valid press stores secret2 and goes to GUESS with turn=0.
- GUESS:
  - valid press: guess<=code, clear bull/cow accumulators, idx<=0, guess_count+1 (saturate), go SCORE.
  - invalid press: error pulse, stay; guess_count unchanged.
- SCORE: exactly 4 cycles, idx 0..3.
  - Target is secret2 if turn=0, else secret1.
  - Per cycle: if guess[idx]==target[idx], bull acc +1; else if guess[idx] equals any target digit, cow acc +1.
  - After idx=3, go RESULT.
- RESULT: one cycle.
  - bulls/cows outputs load the accumulators; result_valid=1 this cycle only.
  - If bulls==4: winner<=turn, increment that player's points (saturate at 2^POINT_W-1), go WIN.
  - Else: turn toggles, go GUESS.
- Latency: press sampled at edge k in GUESS → SCORE during k+1..k+4 → result_valid high in the cycle after edge k+5.
- bulls/cows/winner hold their values until the next RESULT or reset.
- WIN: on press (code ignored, no validation), clear secrets, guess_count and turn, go SET_P1. Points, bulls, cows and winner retained.
- Presses during SCORE or RESULT are dropped, not queued.
- error and result_valid are never both 1 in the same cycle.
- All outputs are registered.

Test Plan:
- Secrets 0x1234, 0x5678; P1 enters 0x5678 → result_valid 1 cycle, 5 cycles after the press edge; bulls=4 cows=0 winner=0 p1_points=1 phase=5 guess_count=1.
- SET_P1: enter 0x1123 → error pulse, phase stays 0; then 0x12A4 → error; then 0x9012 → phase 1, no error.
- Secrets 0x5678 / 0x1234:
  - P1 guesses 0x4321 → bulls=0 cows=4, turn→1.
  - P2 guesses 0x5687 → bulls=2 cows=2, turn→0, guess_count=2.
- Hold enter_button high 20 cycles in SET_P1 with a valid code → exactly one transition (phase 1, not 2). Pulse enter during SCORE → ignored, phase sequence 3,3,3,3,4,2.
- POINT_W=2: P1 wins 5 consecutive games (press in WIN, re-enter secrets) → p1_points 1,2,3,3,3; p2_points=0; turn=0 at each new game start.
- Drop reset low mid-SCORE (idx=2) between clock edges → all outputs 0 and phase=0 immediately without a clock edge; after release, a valid press in SET_P1 proceeds normally.
